bitbakery_serial_rx: RTL
========================

Name: bitbakery_serial_rx

Overview:
- Serial receiver for the BitBakery game link, format 8E1: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Counterpart of the serial transmitter.
- Oversamples the line using the system clock, samples each bit at its midpoint, and delivers the byte with parity and framing status as a one-cycle completion pulse.
- Sits between the board RX pin and the game control unit.

Parameters:
- CLKS_PER_BIT, 5208, system clock cycles per bit (50 MHz / 9600 baud); must be >= 4.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces idle.
- dado_serial  in  1  serial line; idles high.
- dados  out  8  last received byte; held until the next frame completes.
- pronto  out  1  one-cycle pulse at frame completion.
- erro_paridade  out  1  parity status of the last frame; held.
- erro_frame  out  1  stop-bit status of the last frame (1 = stop bit sampled 0); held.
- recebendo  out  1  high while a frame is in progress (all states except inicial).

Behaviour:
- Interface: one clock domain (clock); reset is asynchronous and active-high.
- Reset values: dados=0, pronto=0, erro_paridade=0, erro_frame=0, recebendo=0, state=inicial, counters=0.
- Moore FSM states: inicial, start, dados_st, paridade_st, stop_st, fim, espera_linha.
- inicial:
  - Stays while dado_serial=1.
  - The first cycle dado_serial=0 is cycle T; go to start and clear the tick counter.
- start:
  - Counts to CLKS_PER_BIT/2 (integer division), then samples the line at T+CLKS_PER_BIT/2.
  - Sample 0: go to dados_st.
  - Sample 1 (glitch): return to inicial. No pronto, outputs unchanged.
- dados_st:
  - Samples every CLKS_PER_BIT cycles after the start midpoint.
  - Bit k (k=0..7) is sampled at T+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT into shift register position k (LSB first).
  - A 3-bit bit index wraps 7->0 on leaving the state.
- paridade_st: samples the parity bit at T+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- stop_st: samples the stop bit at T+CLKS_PER_BIT/2+10*CLKS_PER_BIT.
- fim:
  - Occupies exactly the cycle after the stop sample.
  - pronto=1 for that cycle only.
  - dados, erro_paridade and erro_frame update on the same clock edge that enters fim, so they are valid while pronto=1.
  - erro_paridade = XOR(data[7:0], parity bit) (even parity: 0 = ok).
  - erro_frame = ~stop sample.
  - If erro_frame=0, go to inicial; otherwise go to espera_linha.
- espera_linha: waits until dado_serial=1 (break/stuck-low line), then goes to inicial. No spurious frame starts from a low line.
- Errored frames still complete: dados is updated, pronto pulses, and the error flags are set. The consumer decides whether to discard.
- Back-to-back frames: a new start bit may be detected in the cycle after fim (state inicial). No minimum idle gap beyond the stop bit is required.
- Reset mid-frame:
  - Immediately returns to inicial.
  - All outputs go to their reset values; the partial byte is discarded.
  - A line still low after reset is released is treated as a start edge.
- Line changes between sample points are ignored. Only the midpoint sample matters.

Optional Feature:
- Macro: BITBAKERY_SERIAL_RX_SYNC_EN.
- Defined:
  - dado_serial passes through a 2-flop synchronizer (both flops reset to 1) before the FSM.
  - All sample times and pronto shift by +2 cycles relative to the pin.
- Undefined:
  - dado_serial is used directly, for use when the line is already synchronous.
  - Timing is exactly as in Behaviour.
- Port list is identical in both builds.

Test Plan:
All tests use CLKS_PER_BIT=8, feature undefined unless stated.
1. Frame 0x41 with parity 0 and stop 1 -> pronto pulses once at T+85; dados=0x41, erro_paridade=0, erro_frame=0; recebendo=1 from T+1 through T+85.
2. Frame 0x41 with parity bit forced 1 -> pronto pulses; dados=0x41, erro_paridade=1, erro_frame=0.
3. Frame 0x7F (parity 1) with stop bit 0, line held low 30 more cycles -> pronto pulses; erro_frame=1; FSM stays in espera_linha until line goes high; no second pronto.
4. 3-cycle low glitch on an idle line -> no pronto; outputs unchanged; FSM back in inicial at T+5.
5. Two back-to-back frames 0x55 then 0xAA with no idle gap -> two pronto pulses 88 cycles apart; dados=0x55, then 0xAA; both with no errors.
6. reset asserted at T+40 mid-frame, then a clean frame 0x33 -> outputs zero during reset; 0x33 is received correctly. With BITBAKERY_SERIAL_RX_SYNC_EN defined, re-run test 1 -> pronto at T+87.

Source files
------------

// File: rtl/bitbakery_serial_rx.sv
// 8E1 serial receiver for the BitBakery game link: midpoint-sampled start, data, parity and stop bits.
// Define BITBAKERY_SERIAL_RX_SYNC_EN to put a 2-flop synchronizer on dado_serial (adds 2 cycles of latency).
//
// state        | meaning
// inicial      | line idle, waiting for a low level
// start        | timing to the start-bit midpoint, rejecting glitches
// dados_st     | sampling the 8 data bits, LSB first
// paridade_st  | sampling the parity bit
// stop_st      | sampling the stop bit, latching the byte and status
// fim          | one-cycle completion (pronto)
// espera_linha | framing error; waiting for the line to return high
module bitbakery_serial_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  output logic [7:0] dados,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic       recebendo
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    inicial,
    start,
    dados_st,
    paridade_st,
    stop_st,
    fim,
    espera_linha
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             par_q;
  logic             rx;
  logic             tc_half, tc_bit;

`ifdef BITBAKERY_SERIAL_RX_SYNC_EN
  logic [1:0] sync_q;

  // Both flops reset high so the idle line never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], dado_serial};
  end

  assign rx = sync_q[1];
`else
  assign rx = dado_serial;
`endif

  assign tc_half = (cnt == HALF_TC);
  assign tc_bit  = (cnt == BIT_TC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= inicial;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      inicial:      if (!rx) next_state = start;
      start:        if (tc_half) next_state = rx ? inicial : dados_st;
      dados_st:     if (tc_bit && bit_idx == 3'd7) next_state = paridade_st;
      paridade_st:  if (tc_bit) next_state = stop_st;
      stop_st:      if (tc_bit) next_state = fim;
      fim:          next_state = erro_frame ? espera_linha : inicial;
      espera_linha: if (rx) next_state = inicial;
      default:      next_state = inicial;
    endcase
  end

  assign pronto    = (state == fim);
  assign recebendo = (state != inicial);

  // Tick counter counts cycles spent in the current bit; outputs latch on the stop sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      par_q         <= 1'b0;
      dados         <= 8'h00;
      erro_paridade <= 1'b0;
      erro_frame    <= 1'b0;
    end else begin
      case (state)
        start: cnt <= tc_half ? '0 : cnt + 1'b1;
        dados_st: begin
          if (tc_bit) begin
            cnt            <= '0;
            shift[bit_idx] <= rx;
            bit_idx        <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        paridade_st: begin
          if (tc_bit) begin
            cnt   <= '0;
            par_q <= rx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        stop_st: begin
          if (tc_bit) begin
            cnt           <= '0;
            dados         <= shift;
            erro_paridade <= (^shift) ^ par_q;
            erro_frame    <= ~rx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
